// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP_W-bit lookahead group per stage,
// with the group carry registered between stages and valid/ready flow control.
module cla_adder_pipelined #(
  parameter int WIDTH   = 32,
  parameter int GROUP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSTAGE = WIDTH / GROUP_W;

  generate
    if (GROUP_W < 1 || WIDTH < GROUP_W || (WIDTH % GROUP_W) != 0) begin : g_bad_width
      $error("cla_adder_pipelined: WIDTH (%0d) must be a positive multiple of GROUP_W (%0d)",
             WIDTH, GROUP_W);
    end
  endgenerate

  // Flat sum-of-products lookahead: every c[i] is built directly from g/p and c0,
  // never from the previous c[i-1].
  function automatic logic [GROUP_W:0] group_carries(
    input logic [GROUP_W-1:0] g,
    input logic [GROUP_W-1:0] p,
    input logic               c0
  );
    logic [GROUP_W:0] c;
    logic             term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP_W; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             valid_reg [NSTAGE];
  logic [WIDTH-1:0] a_reg     [NSTAGE];
  logic [WIDTH-1:0] b_reg     [NSTAGE];
  logic [WIDTH-1:0] sum_reg   [NSTAGE];
  logic             carry_reg [NSTAGE];
  logic             overflow_reg;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipeline moves as one unit; a stalled result freezes every stage.
  assign out_valid = valid_reg[NSTAGE-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub | carry_in;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      logic               v_in;
      logic               c_in;
      logic [WIDTH-1:0]   a_in;
      logic [WIDTH-1:0]   b_in;
      logic [WIDTH-1:0]   s_in;
      logic [WIDTH-1:0]   s_next;
      logic [GROUP_W-1:0] g_grp;
      logic [GROUP_W-1:0] p_grp;
      logic [GROUP_W:0]   c_grp;

      if (gi == 0) begin : g_first
        assign v_in = in_valid;
        assign a_in = a;
        assign b_in = b_eff;
        assign s_in = '0;
        assign c_in = c0;
      end else begin : g_next
        assign v_in = valid_reg[gi-1];
        assign a_in = a_reg[gi-1];
        assign b_in = b_reg[gi-1];
        assign s_in = sum_reg[gi-1];
        assign c_in = carry_reg[gi-1];
      end

      assign g_grp = a_in[gi*GROUP_W +: GROUP_W] & b_in[gi*GROUP_W +: GROUP_W];
      assign p_grp = a_in[gi*GROUP_W +: GROUP_W] ^ b_in[gi*GROUP_W +: GROUP_W];
      assign c_grp = group_carries(g_grp, p_grp, c_in);

      // Lower groups are already final; only this stage's slice is filled in.
      always_comb begin
        s_next = s_in;
        s_next[gi*GROUP_W +: GROUP_W] = p_grp ^ c_grp[GROUP_W-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          a_reg[gi]     <= '0;
          b_reg[gi]     <= '0;
          sum_reg[gi]   <= '0;
          carry_reg[gi] <= 1'b0;
        end else if (advance) begin
          valid_reg[gi] <= v_in;
          a_reg[gi]     <= a_in;
          b_reg[gi]     <= b_in;
          sum_reg[gi]   <= s_next;
          carry_reg[gi] <= c_grp[GROUP_W];
        end
      end

      if (gi == NSTAGE - 1) begin : g_last
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            overflow_reg <= 1'b0;
          end else if (advance) begin
            overflow_reg <= c_grp[GROUP_W] ^ c_grp[GROUP_W-1];
          end
        end
      end
    end
  endgenerate

  assign sum       = sum_reg[NSTAGE-1];
  assign carry_out = carry_reg[NSTAGE-1];
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Self-checking bench for cla_adder_pipelined (WIDTH=32, GROUP_W=8, four-cycle latency),
// using an arithmetic reference model and a queue of expected results in acceptance order.
module tb_cla_adder_pipelined;

  localparam int WIDTH   = 32;
  localparam int GROUP_W = 8;
  localparam int NSTAGE  = WIDTH / GROUP_W;
  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        carry_in = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  cla_adder_pipelined #(.WIDTH(WIDTH), .GROUP_W(GROUP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic ci);
    res_t            r;
    longint          sx;
    longint          sy;
    longint          sres;
    logic [63:0]     ures;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r.sum  = x - y;
      r.cout = (x >= y);
      sres   = sx - sy;
    end else begin
      ures   = {32'b0, x} + {32'b0, y} + {63'b0, ci};
      r.sum  = ures[31:0];
      r.cout = ures[32];
      sres   = sx + sy + longint'({63'b0, ci});
    end
    r.ovf = (sres > SMAX) || (sres < SMIN);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b, sub, carry_in));
  end

  task automatic rand_op();
    a        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    b        = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
    sub      = 1'($urandom_range(0, 1));
    carry_in = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry_out: got %b want 0", carry_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [31:0] op_a [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h10, 32'd7, 32'h8000_0000};
    logic [31:0] op_b [6] = '{32'd1, 32'd1, 32'd7, 32'h20, 32'd5, 32'd1};
    logic        op_s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        op_c [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ex_s [6] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h31, 32'h2, 32'h7FFF_FFFF};
    logic        ex_c [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        ex_o [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int          got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 6) begin
        in_valid = 1'b1; a = op_a[cyc]; b = op_b[cyc]; sub = op_s[cyc]; carry_in = op_c[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && got < 6) begin
        $display("directed %0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b at cycle %0d",
                 got, op_a[got], op_b[got], op_s[got], op_c[got], sum, carry_out, overflow, cyc);
        checks++; if (sum !== ex_s[got]) begin errors++; $display("FAIL directed_sum[%0d]: got %h want %h", got, sum, ex_s[got]); end
        checks++; if (carry_out !== ex_c[got]) begin errors++; $display("FAIL directed_cout[%0d]: got %b want %b", got, carry_out, ex_c[got]); end
        checks++; if (overflow !== ex_o[got]) begin errors++; $display("FAIL directed_ovf[%0d]: got %b want %b", got, overflow, ex_o[got]); end
        checks++; if (cyc != got + NSTAGE) begin errors++; $display("FAIL directed_latency[%0d]: got cycle %0d want %0d", got, cyc, got + NSTAGE); end
        got++;
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL directed_count: got %0d want 6", got); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int          issued = 0;
    int          got = 0;
    int          cyc = 0;
    int          stall_left = 0;
    int          last_cyc = -1;
    bit          accepted;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_sum = '0;
    logic        prev_cout = 1'b0;
    logic        prev_ovf = 1'b0;
    res_t        exp_r;
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rand_op(); in_valid = 1'b1;
    while (got < 8 && cyc < 64) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({out_valid, sum, carry_out, overflow} !== {1'b1, prev_sum, prev_cout, prev_ovf}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h %b %b want v=1 %h %b %b",
                   out_valid, sum, carry_out, overflow, prev_sum, prev_cout, prev_ovf);
        end
      end
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum = sum; prev_cout = carry_out; prev_ovf = overflow;
      accepted = in_valid && in_ready;
      if (accepted) issued++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got result %h with nothing pending, want none", sum);
        end else begin
          exp_r = exp_q.pop_front();
          if ({overflow, carry_out, sum} !== exp_r) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h/%b/%b want %h/%b/%b",
                     got, sum, carry_out, overflow, exp_r.sum, exp_r.cout, exp_r.ovf);
          end
        end
        $display("b2b %0d: sum=%h cout=%b ovf=%b at cycle %0d", got, sum, carry_out, overflow, cyc);
        got++;
        last_cyc = cyc;
        if (got == 1) stall_left = 3;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        if (issued < 8) rand_op();
        else in_valid = 1'b0;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
    // The eighth result is handed over in cycle 14 and is gone by cycle 4+8+3 = 15.
    checks++; if (last_cyc != NSTAGE + 8 + 3 - 1) begin errors++; $display("FAIL b2b_completion: got cycle %0d want %0d", last_cyc, NSTAGE + 8 + 3 - 1); end
  endtask

  task automatic test_reset_inflight();
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_op(); in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got out_valid %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_async_valid: got %b want 0", out_valid); end
    checks++; if ({sum, carry_out, overflow} !== 34'h0) begin errors++; $display("FAIL inflight_async_data: got %h/%b/%b want 0/0/0", sum, carry_out, overflow); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_stale: got out_valid %b want 0 (cycle %0d)", out_valid, i); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inflight_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    int   acc = 0;
    int   got = 0;
    int   cyc = 0;
    res_t exp_r;
    exp_q.delete();
    @(posedge clk); #1;
    rand_op(); in_valid = 1'b1; out_ready = 1'b1;
    while ((acc < N || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL random_extra: got result %h with nothing pending, want none", sum);
        end else begin
          exp_r = exp_q.pop_front();
          if ({overflow, carry_out, sum} !== exp_r) begin
            errors++;
            $display("FAIL random_result[%0d]: got %h/%b/%b want %h/%b/%b",
                     got, sum, carry_out, overflow, exp_r.sum, exp_r.cout, exp_r.ovf);
          end
        end
        $display("random %0d: sum=%h cout=%b ovf=%b", got, sum, carry_out, overflow);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      rand_op();
      in_valid  = (acc < N) && ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != N) begin errors++; $display("FAIL random_count: got %0d results want %0d (cycles %0d)", got, N, cyc); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
